// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch and its decade counters.
package stopwatch_pkg;
   typedef enum logic {ST_STOP, ST_RUN} sw_state_t;
   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // A digit at 9, or an out-of-range value left by an upset, rolls to 0 with carry.
   function automatic logic bcd_at_limit(input bcd_digit_t d);
      return d >= BCD_MAX;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// One decade counter: clears, or increments on inc with a combinational carry out.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output bcd_digit_t q,
   output logic       carry
);

   assign carry = inc && bcd_at_limit(q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= bcd_at_limit(q) ? bcd_digit_t'(0) : q + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch: key synchronizers, press detection, run/stop FSM,
// tick prescaler and a ripple-carry chain of decade counters.
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 100,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    key_ss_n,
   input  logic                    key_clr_n,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    running,
   output logic                    wrap
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic                  ss_p0, ss_p1, ss_p2;
   logic                  clr_p0, clr_p1, clr_p2;
   logic                  ss_ev, clr_ev, tick, all_nine;
   sw_state_t             state;
   logic [PW-1:0]         pre;
   logic [NUM_DIGITS:0]   inc_chain;
   logic [NUM_DIGITS-1:0] nine;

   // Stage p0/p1 synchronize the raw pins; p2 holds the previous synced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_p0  <= 1'b1;
         ss_p1  <= 1'b1;
         ss_p2  <= 1'b1;
         clr_p0 <= 1'b1;
         clr_p1 <= 1'b1;
         clr_p2 <= 1'b1;
      end else begin
         ss_p0  <= key_ss_n;
         ss_p1  <= ss_p0;
         ss_p2  <= ss_p1;
         clr_p0 <= key_clr_n;
         clr_p1 <= clr_p0;
         clr_p2 <= clr_p1;
      end
   end

   assign ss_ev  = ss_p2 & ~ss_p1;
   assign clr_ev = clr_p2 & ~clr_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_STOP;
         running <= 1'b0;
      end else if (ss_ev) begin
         if (state == ST_STOP) begin
            state   <= ST_RUN;
            running <= 1'b1;
         end else begin
            state   <= ST_STOP;
            running <= 1'b0;
         end
      end
   end

   assign tick = (state == ST_RUN) && (pre == PRE_LAST);

   // The prescaler freezes in STOP so a pause resumes mid-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (clr_ev) begin
         pre <= '0;
      end else if (state == ST_RUN) begin
         pre <= tick ? '0 : pre + PW'(1);
      end
   end

   assign inc_chain[0] = tick;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr_ev),
         .inc   (inc_chain[i]),
         .q     (bcd_out[4*i +: 4]),
         .carry (inc_chain[i+1])
      );
      assign nine[i] = (bcd_out[4*i +: 4] == BCD_MAX);
   end

   assign all_nine = &nine;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
      end else begin
         wrap <= inc_chain[NUM_DIGITS] & all_nine & ~clr_ev;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: directed key presses with cycle-stamped expectations.
module tb_bcd_stopwatch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_ss_n = 1'b1, key_clr_n = 1'b1;
   logic        fkey_ss_n = 1'b1, fkey_clr_n = 1'b1;
   logic [15:0] bcd, fbcd;
   logic        run, frun, wr, fwr;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      int          cyc;
      bit          fast;
      logic [15:0] bcd;
      logic        run;
      logic        wrap;
      string       name;
   } exp_t;

   exp_t sb[$];

   bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .NUM_DIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_ss_n  (key_ss_n),
      .key_clr_n (key_clr_n),
      .bcd_out   (bcd),
      .running   (run),
      .wrap      (wr)
   );

   // Second instance with DIV=2 so a full 9999 -> 0000 wrap fits in the run.
   bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(50), .NUM_DIGITS(4)) dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_ss_n  (fkey_ss_n),
      .key_clr_n (fkey_clr_n),
      .bcd_out   (fbcd),
      .running   (frun),
      .wrap      (fwr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic expect_at(input int c, input bit fast, input logic [15:0] b,
                            input logic r, input logic w, input string name);
      exp_t e;
      e.cyc  = c;
      e.fast = fast;
      e.bcd  = b;
      e.run  = r;
      e.wrap = w;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int which, input int c, input int hold);
      wait_to(c);
      case (which)
         0: key_ss_n  = 1'b0;
         1: key_clr_n = 1'b0;
         default: fkey_ss_n = 1'b0;
      endcase
      wait_to(c + hold);
      case (which)
         0: key_ss_n  = 1'b1;
         1: key_clr_n = 1'b1;
         default: fkey_ss_n = 1'b1;
      endcase
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            if (sb[i].fast) begin
               cmp({sb[i].name, ".bcd"},  fbcd,          sb[i].bcd);
               cmp({sb[i].name, ".run"},  {15'd0, frun}, {15'd0, sb[i].run});
               cmp({sb[i].name, ".wrap"}, {15'd0, fwr},  {15'd0, sb[i].wrap});
            end else begin
               cmp({sb[i].name, ".bcd"},  bcd,           sb[i].bcd);
               cmp({sb[i].name, ".run"},  {15'd0, run},  {15'd0, sb[i].run});
               cmp({sb[i].name, ".wrap"}, {15'd0, wr},   {15'd0, sb[i].wrap});
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s: never sampled, expected at cycle %0d now %0d",
                     sb[i].name, sb[i].cyc, cyc);
            sb.delete(i);
         end
      end
   end

   initial begin
      int p, q, r, t, f;
      #12 rst_n = 1'b1;
      wait_to(3);
      expect_at(5, 0, 16'h0000, 0, 0, "reset_state");

      p = 10;
      expect_at(p + 2,   0, 16'h0000, 0, 0, "ss_latency_pre");
      expect_at(p + 3,   0, 16'h0000, 1, 0, "ss_latency_run");
      expect_at(p + 12,  0, 16'h0000, 1, 0, "first_tick_pre");
      expect_at(p + 13,  0, 16'h0001, 1, 0, "first_tick");
      expect_at(p + 102, 0, 16'h0009, 1, 0, "carry_pre");
      expect_at(p + 103, 0, 16'h0010, 1, 0, "carry_9_to_10");
      expect_at(p + 150, 0, 16'h0014, 1, 0, "count_before_reset");
      press(0, p, 100);

      wait_to(p + 152);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_reset.bcd",  bcd,          16'h0000);
      cmp("async_reset.run",  {15'd0, run}, 16'h0000);
      cmp("async_reset.wrap", {15'd0, wr},  16'h0000);
      wait_to(p + 154);
      #2 rst_n = 1'b1;
      expect_at(p + 156, 0, 16'h0000, 0, 0, "post_reset_idle");

      p = p + 160;
      expect_at(p + 3,   0, 16'h0000, 1, 0, "restart_run");
      expect_at(p + 427, 0, 16'h0042, 1, 0, "count_42");
      expect_at(p + 428, 0, 16'h0042, 0, 0, "stop_at_42");
      expect_at(p + 628, 0, 16'h0042, 0, 0, "hold_42");
      q = p + 640;
      expect_at(q + 7,   0, 16'h0042, 1, 0, "resume_pre");
      expect_at(q + 8,   0, 16'h0043, 1, 0, "resume_after_5");
      expect_at(q + 807, 0, 16'h0122, 1, 0, "pre_clear");
      expect_at(q + 808, 0, 16'h0000, 1, 0, "clear_beats_tick");
      expect_at(q + 817, 0, 16'h0000, 1, 0, "clear_prescaler_pre");
      expect_at(q + 818, 0, 16'h0001, 1, 0, "clear_prescaler_tick");
      press(0, p, 5);
      press(0, p + 425, 5);
      press(0, q, 5);
      press(1, q + 805, 5);

      r = q + 850;
      t = r + 1010;
      expect_at(r + 3,    0, 16'h0004, 0, 0, "held_toggle");
      expect_at(r + 500,  0, 16'h0004, 0, 0, "held_no_retoggle");
      expect_at(r + 1003, 0, 16'h0004, 0, 0, "held_release");
      expect_at(t + 3,    0, 16'h0004, 1, 0, "single_press");
      expect_at(t + 7,    0, 16'h0004, 1, 0, "single_press_pre");
      expect_at(t + 8,    0, 16'h0005, 1, 0, "single_press_tick");
      expect_at(t + 30,   0, 16'h0007, 1, 0, "single_press_steady");
      press(0, r, 1000);
      press(0, t, 4);

      f = t + 40;
      expect_at(f + 3,     1, 16'h0000, 1, 0, "fast_run");
      expect_at(f + 20001, 1, 16'h9999, 1, 0, "fast_9999");
      expect_at(f + 20002, 1, 16'h9999, 1, 0, "fast_9999_hold");
      expect_at(f + 20003, 1, 16'h0000, 1, 1, "wrap_pulse");
      expect_at(f + 20004, 1, 16'h0000, 1, 0, "wrap_one_cycle");
      expect_at(f + 20005, 1, 16'h0001, 1, 0, "after_wrap");
      press(2, f, 5);

      wait_to(f + 20010);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
